ex_mem_pipe_reg: RTL
====================

# ex_mem_pipe_reg

Parametrised Execute-to-Memory pipeline register with a valid/ready handshake, synchronous flush, bubble write-kill masking, an optional skid entry and a saturating stall-cycle counter. It sits between the ALU/branch-target logic of Execute and the data-memory/branch-resolve logic of Memory. It replaces the bare always-latching stage register, so the pipeline can stall, squash and insert bubbles without corrupting architectural state.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, store data and branch target
- REG_W, 5, width of destination register index
- CTRL_W, 12, width of packed control bus (read/write enables, widths, branch select, RegWrite, MemToReg)
- KILL_MASK, 12'h0C3, control bits forced to 0 whenever out_valid=0 (write and read enables)
- STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Flush  in  1  squash all held and incoming entries this cycle
- in_valid  in  1  Execute presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bus
- in_alu  in  DATA_W  ALU result / memory address
- in_store  in  DATA_W  store data (RegData2)
- in_target  in  DATA_W  PC+4+offset branch target
- in_zero  in  1  ALU zero flag
- in_dest  in  REG_W  selected destination register
- out_valid  out  1  Memory-side entry valid
- out_ready  in  1  Memory stage can accept
- out_ctrl, out_alu, out_store, out_target, out_zero, out_dest  out  as inputs  registered payload
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1, out_ready=0

## Operation
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Main entry M holds the output. Skid entry S (if compiled in) absorbs one accept while M is stalled.
- Accept with M empty, or M emitting, and S empty: payload loads into M.
- Accept while M is stalled: payload loads into S.
- M emits while S is full: S moves into M and S empties. Program order is always preserved: S is never bypassed by the input.
- Flush: M.valid and S.valid clear and the same-cycle input is dropped. Flush has priority over accept and emit. Payload registers keep their value.
- out_ctrl = M.ctrl & ~(out_valid ? 0 : KILL_MASK). A bubble can never write the register file or memory.
- stall_cnt increments on each out_valid && !out_ready cycle and saturates at all-ones. It does not clear on Flush.
- Reset: out_valid=0, S empty, every payload output=0, out_ctrl=0, stall_cnt=0, in_ready=1 from the first cycle after Reset deasserts. Reset mid-stall discards both entries.

## Timing
- Latency: one cycle from accept to out_valid=1 with the payload on the outputs.
- Throughput: one instruction per cycle while out_ready=1.
- With skid: in_ready = !S.valid, driven directly from a register with no combinational path from out_ready.
- Without skid: in_ready = out_ready || !out_valid, which is combinational.
- Simultaneous accept and emit with S empty: M reloads and out_valid stays 1.
- Simultaneous accept and emit with S full: this cannot occur, because in_ready=0.
- Flush together with in_valid=1: the next cycle shows out_valid=0.

## Configuration
- EXMEM_SKID_EN defined: the S entry is built and in_ready is registered. A stalled stage accepts exactly one further instruction before in_ready falls.
- EXMEM_SKID_EN undefined: there is no S entry, in_ready is combinational as above, and the stage holds at most one instruction.

## Test plan
- Reset held 3 cycles with in_valid=1, in_alu=32'hDEADBEEF -> out_valid=0, out_alu=0, stall_cnt=0 throughout, in_ready=1 after release.
- Streaming, out_ready=1, in_alu=1,2,3 on consecutive cycles -> out_alu=1,2,3 one cycle later each, out_valid continuously 1.
- SKID_EN: out_ready=0 with M=A, then present B -> B accepted, in_ready=0 next cycle, C held off. Raise out_ready -> outputs A, B, C in order with no loss or duplication. stall_cnt equals the number of stalled cycles.
- Flush while M and S are full and in_valid=1 -> next cycle out_valid=0, out_ctrl & 12'h0C3 = 0, in_ready=1.
- Bubble: in_valid=0 with in_ctrl=12'hFFF -> out_ctrl=12'hF3C and out_valid=0.
- stall_cnt with STALL_CNT_W=4, held stalled 20 cycles -> saturates at 4'hF and stays there.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// Execute-to-Memory pipeline register: valid/ready handshake, flush, bubble write-kill
// masking and a saturating stall counter. Define EXMEM_SKID_EN to build the skid entry.
module ex_mem_pipe_reg #(
   parameter int                DATA_W      = 32,
   parameter int                REG_W       = 5,
   parameter int                CTRL_W      = 12,
   parameter logic [CTRL_W-1:0] KILL_MASK   = 12'h0C3,
   parameter int                STALL_CNT_W = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_alu,
   input  logic [DATA_W-1:0]      in_store,
   input  logic [DATA_W-1:0]      in_target,
   input  logic                   in_zero,
   input  logic [REG_W-1:0]       in_dest,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_alu,
   output logic [DATA_W-1:0]      out_store,
   output logic [DATA_W-1:0]      out_target,
   output logic                   out_zero,
   output logic [REG_W-1:0]       out_dest,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] store;
      logic [DATA_W-1:0] target;
      logic              zero;
      logic [REG_W-1:0]  dest;
   } entry_t;

   entry_t in_entry;
   entry_t m_entry, m_entry_d;
   logic   m_valid, m_valid_d;
   logic   m_free;

   assign in_entry = '{ctrl: in_ctrl, alu: in_alu, store: in_store,
                       target: in_target, zero: in_zero, dest: in_dest};

   // M can take new data when it is empty or its current entry leaves this cycle.
   assign m_free = !m_valid || out_ready;

`ifdef EXMEM_SKID_EN
   entry_t s_entry, s_entry_d;
   logic   s_empty, s_empty_d;

   // in_ready is the S-empty flop itself, so out_ready never reaches it combinationally.
   assign in_ready = s_empty;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      m_entry_d = m_entry;
      m_valid_d = m_valid;
      s_entry_d = s_entry;
      s_empty_d = s_empty;
      if (Flush) begin
         m_valid_d = 1'b0;
         s_empty_d = 1'b1;
      end else if (!s_empty) begin
         if (out_ready) begin
            m_entry_d = s_entry;
            s_empty_d = 1'b1;
         end
      end else if (m_free) begin
         m_entry_d = in_entry;
         m_valid_d = in_valid;
      end else if (in_valid) begin
         s_entry_d = in_entry;
         s_empty_d = 1'b0;
      end
   end

   // NOTE: s_entry is data-only storage guarded by s_empty, so it needs no reset.
   always_ff @(posedge Clock) begin
      s_entry <= s_entry_d;
   end

   always_ff @(posedge Clock) begin
      if (Reset) s_empty <= 1'b1;
      else       s_empty <= s_empty_d;
   end
`else
   assign in_ready = m_free;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      m_entry_d = m_entry;
      m_valid_d = m_valid;
      if (Flush) begin
         m_valid_d = 1'b0;
      end else if (m_free) begin
         // Bubbles load too; the kill mask keeps their control bits harmless.
         m_entry_d = in_entry;
         m_valid_d = in_valid;
      end
   end
`endif

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         m_valid <= 1'b0;
         m_entry <= '0;
      end else begin
         m_valid <= m_valid_d;
         m_entry <= m_entry_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         stall_cnt <= '0;
      else if (m_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
   end

   assign out_valid  = m_valid;
   assign out_ctrl   = m_entry.ctrl & ~(m_valid ? {CTRL_W{1'b0}} : KILL_MASK);
   assign out_alu    = m_entry.alu;
   assign out_store  = m_entry.store;
   assign out_target = m_entry.target;
   assign out_zero   = m_entry.zero;
   assign out_dest   = m_entry.dest;

endmodule
